// File: rtl/shifter_arb_pkg.sv
// Shared types and constants for the shifter arbiter: FSM states, the latched
// shift operation, and the rotate second-pass amount helper.
package shifter_arb_pkg;

  localparam int SHIFT_W = 32;
  localparam int SHFT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROT2  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] in;
    logic [SHFT_W-1:0]  shft;
    logic               left;
    logic               arith;
    logic               rot;
  } shift_op_t;

  // Opposite-direction amount for the second rotate pass: (32 - n) mod 32.
  function automatic logic [SHFT_W-1:0] rot_complement(input logic [SHFT_W-1:0] n);
    return (~n) + 5'd1;
  endfunction

endpackage

// File: rtl/shifter_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer and returns the pointer for the following arbitration.
module rr_arbiter
  import shifter_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_next_ptr
);

  always_comb begin
    int   idx;
    logic found;
    o_gnt      = {NUM_REQ{1'b0}};
    o_next_ptr = i_ptr;
    found      = 1'b0;
    idx        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(i_ptr) + off) % NUM_REQ;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_next_ptr = PTR_W'((idx + 1) % NUM_REQ);
        found      = 1'b1;
      end else begin
        found      = found;
      end
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Shares one external combinational barrel shifter among NUM_REQ requesters
// with round-robin grant. Rotate support is built with SHIFTER_ARB_ROTATE_EN.
module shifter_arbiter
  import shifter_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        CLK,
  input  logic                        N_RST,
  input  logic [NUM_REQ-1:0]          REQ_VALID,
  output logic [NUM_REQ-1:0]          REQ_READY,
  input  logic [SHIFT_W*NUM_REQ-1:0]  REQ_IN,
  input  logic [SHFT_W*NUM_REQ-1:0]   REQ_SHFT,
  input  logic [NUM_REQ-1:0]          REQ_LEFT,
  input  logic [NUM_REQ-1:0]          REQ_ARITH,
`ifdef SHIFTER_ARB_ROTATE_EN
  input  logic [NUM_REQ-1:0]          REQ_ROT,
`endif
  output logic [NUM_REQ-1:0]          RSP_VALID,
  input  logic [NUM_REQ-1:0]          RSP_READY,
  output logic [SHIFT_W-1:0]          RSP_DATA,
  output logic [SHIFT_W-1:0]          SH_IN,
  output logic [SHFT_W-1:0]           SH_SHFT,
  output logic                        SH_LEFT,
  output logic                        SH_ARITH,
  input  logic [SHIFT_W-1:0]          SH_OUT
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] r_owner;
  shift_op_t          r_op;
  shift_op_t          w_req_op;
  logic [SHIFT_W-1:0] r_result;
  logic               w_accept;
  logic               w_rsp_take;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req      (REQ_VALID),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_ptr_nxt)
  );

  // Select the granted requester's payload (grant is one-hot or zero).
  always_comb begin
    w_req_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_op.in    = w_req_op.in   | (REQ_IN[SHIFT_W*i +: SHIFT_W] & {SHIFT_W{w_gnt[i]}});
      w_req_op.shft  = w_req_op.shft | (REQ_SHFT[SHFT_W*i +: SHFT_W] & {SHFT_W{w_gnt[i]}});
      w_req_op.left  = w_req_op.left  | (REQ_LEFT[i] & w_gnt[i]);
      w_req_op.arith = w_req_op.arith | (REQ_ARITH[i] & ~REQ_LEFT[i] & w_gnt[i]);
`ifdef SHIFTER_ARB_ROTATE_EN
      w_req_op.rot   = w_req_op.rot   | (REQ_ROT[i] & w_gnt[i]);
`endif
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  w_state_nxt = w_accept ? SHIFT : IDLE;
`ifdef SHIFTER_ARB_ROTATE_EN
      SHIFT: w_state_nxt = r_op.rot ? ROT2 : RESP;
      ROT2:  w_state_nxt = RESP;
`else
      SHIFT: w_state_nxt = RESP;
`endif
      RESP:  w_state_nxt = w_rsp_take ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset gates the grant so REQ_READY is low while N_RST is asserted.
  always_comb begin
    w_accept   = N_RST && (r_state == IDLE) && (|w_gnt);
    REQ_READY  = w_accept ? w_gnt : {NUM_REQ{1'b0}};
    w_rsp_take = (r_state == RESP) && (|(r_owner & RSP_READY));
    RSP_VALID  = (r_state == RESP) ? r_owner : {NUM_REQ{1'b0}};
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_op    <= '0;
      r_owner <= {NUM_REQ{1'b0}};
      r_ptr   <= {PTR_W{1'b0}};
    end else if (w_accept) begin
      r_op    <= w_req_op;
      r_owner <= w_gnt;
      r_ptr   <= w_ptr_nxt;
    end else begin
      r_op    <= r_op;
      r_owner <= r_owner;
      r_ptr   <= r_ptr;
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_result <= 32'd0;
    end else begin
      case (r_state)
        SHIFT:   r_result <= SH_OUT;
`ifdef SHIFTER_ARB_ROTATE_EN
        ROT2:    r_result <= r_result | SH_OUT;
`endif
        default: r_result <= r_result;
      endcase
    end
  end

  assign RSP_DATA = r_result;
  assign SH_IN    = r_op.in;
  assign SH_ARITH = r_op.arith & ~r_op.rot;

`ifdef SHIFTER_ARB_ROTATE_EN
  logic r_pass2;

  // Second rotate pass flag; it stays set after ROT2 so SH_* do not move
  // until the next operation is accepted.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_pass2 <= 1'b0;
    end else if (w_accept) begin
      r_pass2 <= 1'b0;
    end else if ((r_state == SHIFT) && r_op.rot) begin
      r_pass2 <= 1'b1;
    end else begin
      r_pass2 <= r_pass2;
    end
  end

  assign SH_SHFT = r_pass2 ? rot_complement(r_op.shft) : r_op.shft;
  assign SH_LEFT = r_op.left ^ r_pass2;
`else
  assign SH_SHFT = r_op.shft;
  assign SH_LEFT = r_op.left;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter paired with a behavioural barrel shifter;
// rotate cases run when SHIFTER_ARB_ROTATE_EN is defined.
module tb_shifter_arbiter;

  localparam int N = 2;

  logic          CLK = 1'b0;
  logic          N_RST;
  logic [N-1:0]  REQ_VALID, REQ_READY, REQ_LEFT, REQ_ARITH;
  logic [32*N-1:0] REQ_IN;
  logic [5*N-1:0]  REQ_SHFT;
`ifdef SHIFTER_ARB_ROTATE_EN
  logic [N-1:0]  REQ_ROT;
`endif
  logic [N-1:0]  RSP_VALID, RSP_READY;
  logic [31:0]   RSP_DATA, SH_IN, SH_OUT;
  logic [4:0]    SH_SHFT;
  logic          SH_LEFT, SH_ARITH;

  shifter_arbiter #(.NUM_REQ(N)) dut (
    .CLK(CLK), .N_RST(N_RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_IN(REQ_IN),
    .REQ_SHFT(REQ_SHFT), .REQ_LEFT(REQ_LEFT), .REQ_ARITH(REQ_ARITH),
`ifdef SHIFTER_ARB_ROTATE_EN
    .REQ_ROT(REQ_ROT),
`endif
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .SH_IN(SH_IN), .SH_SHFT(SH_SHFT), .SH_LEFT(SH_LEFT), .SH_ARITH(SH_ARITH),
    .SH_OUT(SH_OUT)
  );

  // The external barrel shifter the block drives.
  assign SH_OUT = SH_LEFT ? (SH_IN << SH_SHFT)
                : (SH_ARITH ? unsigned'($signed(SH_IN) >>> SH_SHFT) : (SH_IN >> SH_SHFT));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {int owner; logic [31:0] data; int lat; int acc;} exp_t;
  exp_t sbq[$];
  int   gnt_log[$];
  int   acc_log[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   seen  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] in, input logic [4:0] sh,
                                        input bit left, input bit arith, input bit rot);
    logic [63:0] t;
    t = {in, in};
    if (rot) begin
      if (left) begin
        t = t << sh;
        return t[63:32];
      end
      t = t >> sh;
      return t[31:0];
    end
    if (left) return in << sh;
    if (arith && in[31]) return (in >> sh) | ~(32'hFFFF_FFFF >> sh);
    return in >> sh;
  endfunction

  // Response monitor: owner, data, latency and stability while valid.
  always @(negedge CLK) begin
    if (N_RST === 1'b1 && RSP_VALID !== '0) begin
      if (sbq.size() == 0) begin
        check_eq("spurious_rsp", 32'(RSP_VALID), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check_eq("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
        end
        check_eq("rsp_owner", 32'(RSP_VALID), 32'(1 << sbq[0].owner));
        check_eq("rsp_data", RSP_DATA, sbq[0].data);
        check_eq("ready_in_resp", 32'(REQ_READY), 32'd0);
        if ((RSP_VALID & RSP_READY) != '0) begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [31:0] in, input logic [4:0] sh,
                       input bit left, input bit arith, input bit rot, input logic [31:0] exp);
    int waited = 0;
    REQ_IN[32*idx +: 32]  = in;
    REQ_SHFT[5*idx +: 5]  = sh;
    REQ_LEFT[idx]         = left;
    REQ_ARITH[idx]        = arith;
`ifdef SHIFTER_ARB_ROTATE_EN
    REQ_ROT[idx]          = rot;
`endif
    REQ_VALID[idx]        = 1'b1;
    @(negedge CLK);
    while (!REQ_READY[idx] && waited < 40) begin
      waited++;
      @(negedge CLK);
    end
    if (REQ_READY[idx]) begin
      sbq.push_back('{owner: idx, data: exp, lat: (rot ? 3 : 2), acc: cyc});
      gnt_log.push_back(idx);
      acc_log.push_back(cyc);
    end
    check_eq("grant", 32'(REQ_READY), 32'(1 << idx));
    @(posedge CLK);
    #1;
    REQ_VALID[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sbq.size() != 0 && t < 60) begin
      t++;
      @(negedge CLK);
    end
    if (sbq.size() != 0) check_eq("drain_timeout", 32'(sbq.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rin;
    logic [4:0]  rsh;
    bit          rl, ra;
    int          ridx;
    N_RST = 1'b0; REQ_VALID = '0; REQ_IN = '0; REQ_SHFT = '0;
    REQ_LEFT = '0; REQ_ARITH = '0; RSP_READY = '1;
`ifdef SHIFTER_ARB_ROTATE_EN
    REQ_ROT = '0;
`endif
    repeat (2) @(negedge CLK);
    check_eq("rst_req_ready", 32'(REQ_READY), 32'd0);
    check_eq("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check_eq("rst_rsp_data", RSP_DATA, 32'd0);
    check_eq("rst_sh_in", SH_IN, 32'd0);
    check_eq("rst_sh_ctl", {25'd0, SH_SHFT, SH_LEFT, SH_ARITH}, 32'd0);
    @(posedge CLK); #1; N_RST = 1'b1;
    @(posedge CLK); #1;

    issue(0, 32'h0000_00F0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0000_0F00);
    wait_idle();
    issue(1, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    wait_idle();
    issue(1, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
    wait_idle();

    // Both requesters streaming: strict alternation, one op per 3 cycles.
    gnt_log.delete(); acc_log.delete();
    fork
      for (int k = 0; k < 4; k++)
        issue(0, 32'h1234_5678 ^ 32'(k), 5'(k + 1), 1'b1, 1'b0, 1'b0,
              model(32'h1234_5678 ^ 32'(k), 5'(k + 1), 1'b1, 1'b0, 1'b0));
      for (int k = 0; k < 4; k++)
        issue(1, 32'h9ABC_DEF0 + 32'(k), 5'(k + 3), 1'b0, 1'b1, 1'b0,
              model(32'h9ABC_DEF0 + 32'(k), 5'(k + 3), 1'b0, 1'b1, 1'b0));
    join
    wait_idle();
    check_eq("t3_count", 32'(gnt_log.size()), 32'd8);
    for (int k = 0; k < gnt_log.size(); k++) check_eq("t3_gnt_order", 32'(gnt_log[k]), 32'(k % 2));
    for (int k = 1; k < acc_log.size(); k++) check_eq("t3_spacing", 32'(acc_log[k] - acc_log[k-1]), 32'd3);

    // Response back-pressure on requester 0 while requester 1 waits.
    RSP_READY[0] = 1'b0;
    issue(0, 32'hCAFE_0001, 5'd8, 1'b1, 1'b0, 1'b0, 32'hFE00_0100);
    fork
      issue(1, 32'h0000_FF00, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0000_0FF0);
    join_none
    repeat (6) @(posedge CLK);
    check_eq("t4_held_valid", 32'(RSP_VALID), 32'd1);
    #1; RSP_READY[0] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("t4_idle_next", 32'(REQ_READY), 32'd2);
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    issue(0, 32'h0F0F_0F0F, 5'd3, 1'b1, 1'b0, 1'b0, 32'h7878_7878);
    #2; N_RST = 1'b0;
    #1;
    check_eq("t5_req_ready", 32'(REQ_READY), 32'd0);
    check_eq("t5_rsp_valid", 32'(RSP_VALID), 32'd0);
    check_eq("t5_rsp_data", RSP_DATA, 32'd0);
    check_eq("t5_sh_in", SH_IN, 32'd0);
    check_eq("t5_sh_ctl", {25'd0, SH_SHFT, SH_LEFT, SH_ARITH}, 32'd0);
    sbq.delete(); seen = 1'b0;
    @(posedge CLK); #1; N_RST = 1'b1;
    gnt_log.delete();
    fork
      issue(0, 32'h0000_0011, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0022);
      issue(1, 32'h0000_0100, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
    join
    wait_idle();
    check_eq("t5_ptr_reset", 32'(gnt_log[0]), 32'd0);
    issue(1, 32'hF000_0000, 5'd4, 1'b0, 1'b1, 1'b0, 32'hFF00_0000);
    wait_idle();

    for (int k = 0; k < 10; k++) begin
      ridx = int'($urandom_range(0, N - 1));
      rin  = $urandom;
      rsh  = 5'($urandom);
      rl   = 1'($urandom);
      ra   = 1'($urandom);
      issue(ridx, rin, rsh, rl, ra, 1'b0, model(rin, rsh, rl, ra, 1'b0));
    end
    wait_idle();

`ifdef SHIFTER_ARB_ROTATE_EN
    issue(0, 32'h8000_0001, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0003);
    wait_idle();
    issue(0, 32'h8000_0001, 5'd0, 1'b1, 1'b0, 1'b1, 32'h8000_0001);
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      ridx = int'($urandom_range(0, N - 1));
      rin  = $urandom;
      rsh  = 5'($urandom);
      rl   = 1'($urandom);
      issue(ridx, rin, rsh, rl, 1'b1, 1'b1, model(rin, rsh, rl, 1'b1, 1'b1));
    end
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
